// File: rtl/seg7_capture.sv
// seg7_capture: recovers hex digits from a multiplexed, active-low seven-segment bus.
// A (segment, select) pair is taken once it has been held for STABLE_CYCLES edges,
// decoded, and written into the selected digit slot(s), with error flags and a frame marker.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  seg_in,
    input  logic [3:0]  sel_in,
    output logic [15:0] digit_val,
    output logic [3:0]  dp_val,
    output logic [3:0]  digit_ok,
    output logic        value_valid,
    output logic        frame_done,
    output logic        pattern_err,
    output logic        sel_err,
    output logic [7:0]  err_cnt
);

    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES);

    // Input sample stage and the previous sample, used to detect a stable run
    logic [7:0] seg_q;
    logic [3:0] sel_q;
    logic [7:0] seg_d;
    logic [3:0] sel_d;
    logic       in_vld;
    logic       prev_vld;

    // Run tracking
    logic [7:0] run_cnt;
    logic [7:0] run_next;
    logic       pair_same;
    logic       taken;
    logic       taken_next;
    logic       accept;

    // Decode results
    logic       pat_legal;
    logic [3:0] pat_nibble;
    logic [3:0] sel_target;
    logic       sel_blank;
    logic       sel_bad;

    // Frame bookkeeping and next-state values
    logic [3:0]  seen_mask;
    logic [3:0]  seen_next;
    logic [15:0] digit_next;
    logic [3:0]  dp_next;
    logic [3:0]  ok_next;
    logic        frame_next;
    logic        perr_next;
    logic        serr_next;

    // Sample the bus every edge; the previous sample lets us tell whether the pair moved
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            seg_q    <= 8'hFF;
            sel_q    <= 4'hF;
            seg_d    <= 8'hFF;
            sel_d    <= 4'hF;
            in_vld   <= 1'b0;
            prev_vld <= 1'b0;
        end else begin
            seg_q    <= seg_in;
            sel_q    <= sel_in;
            seg_d    <= seg_q;
            sel_d    <= sel_q;
            in_vld   <= 1'b1;
            prev_vld <= in_vld;
        end
    end

    // Count how many consecutive samples the pair in seg_q/sel_q has been held, and fire once
    always_comb begin
        run_next   = 8'd0;
        pair_same  = prev_vld && (seg_q == seg_d) && (sel_q == sel_d);
        if (!in_vld) begin
            run_next = 8'd0;
        end else if (!pair_same) begin
            run_next = 8'd1;
        end else if (run_cnt == STABLE_LAST) begin
            run_next = run_cnt;
        end else begin
            run_next = run_cnt + 8'd1;
        end
        accept     = in_vld && (run_next == STABLE_LAST) && !(pair_same && taken);
        taken_next = accept || (pair_same && taken);
    end

    // Run counter and the "already taken" flag that blocks re-acceptance of a held pair
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            run_cnt <= 8'd0;
            taken   <= 1'b0;
        end else begin
            run_cnt <= run_next;
            taken   <= taken_next;
        end
    end

    // Segment pattern to hex nibble; the dp bit is excluded from the match
    always_comb begin
        pat_legal  = 1'b1;
        pat_nibble = 4'h0;
        case (seg_q[6:0])
            7'h40:   pat_nibble = 4'h0;
            7'h79:   pat_nibble = 4'h1;
            7'h24:   pat_nibble = 4'h2;
            7'h30:   pat_nibble = 4'h3;
            7'h19:   pat_nibble = 4'h4;
            7'h12:   pat_nibble = 4'h5;
            7'h02:   pat_nibble = 4'h6;
            7'h78:   pat_nibble = 4'h7;
            7'h00:   pat_nibble = 4'h8;
            7'h10:   pat_nibble = 4'h9;
            7'h08:   pat_nibble = 4'hA;
            7'h03:   pat_nibble = 4'hB;
            7'h46:   pat_nibble = 4'hC;
            7'h21:   pat_nibble = 4'hD;
            7'h06:   pat_nibble = 4'hE;
            7'h0E:   pat_nibble = 4'hF;
            default: pat_legal  = 1'b0;
        endcase
    end

    // Select decode: one low bit picks a digit, all low drives every digit, all high is blank
    always_comb begin
        sel_target = 4'b0000;
        sel_blank  = 1'b0;
        sel_bad    = 1'b0;
        case (sel_q)
            4'b1110: sel_target = 4'b0001;
            4'b1101: sel_target = 4'b0010;
            4'b1011: sel_target = 4'b0100;
            4'b0111: sel_target = 4'b1000;
            4'b0000: sel_target = 4'b1111;
            4'b1111: sel_blank  = 1'b1;
            default: sel_bad    = 1'b1;
        endcase
    end

    // Work out the effect of an accepted pair on digits, flags and the frame mask
    always_comb begin
        digit_next = digit_val;
        dp_next    = dp_val;
        ok_next    = digit_ok;
        seen_next  = seen_mask;
        frame_next = 1'b0;
        perr_next  = 1'b0;
        serr_next  = 1'b0;
        if (accept && !sel_blank) begin
            if (sel_bad) begin
                serr_next = 1'b1;
            end else if (pat_legal) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel_target[i]) begin
                        digit_next[4*i +: 4] = pat_nibble;
                        dp_next[i]           = ~seg_q[7];
                        ok_next[i]           = 1'b1;
                    end
                end
                seen_next = seen_mask | sel_target;
                if ((seen_next == 4'b1111) && (ok_next == 4'b1111)) begin
                    frame_next = 1'b1;
                    seen_next  = 4'b0000;
                end
            end else begin
                perr_next = 1'b1;
                ok_next   = digit_ok & ~sel_target;
            end
        end
    end

    // Output and frame state registers; the pulses last exactly one cycle
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            digit_val   <= 16'h0000;
            dp_val      <= 4'h0;
            digit_ok    <= 4'h0;
            seen_mask   <= 4'h0;
            frame_done  <= 1'b0;
            pattern_err <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            digit_val   <= digit_next;
            dp_val      <= dp_next;
            digit_ok    <= ok_next;
            seen_mask   <= seen_next;
            frame_done  <= frame_next;
            pattern_err <= perr_next;
            sel_err     <= serr_next;
        end
    end

    // Saturating error counter, one step per error pulse
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            err_cnt <= 8'd0;
        end else if ((perr_next || serr_next) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign value_valid = &digit_ok;

endmodule

// File: tb/tb_seg7_capture.sv
// tb_seg7_capture: randomized and directed stimulus for seg7_capture with a queue-based
// scoreboard fed by a history-based reference model of the capture rules.
module tb_seg7_capture;

    localparam int STABLE = 4;

    logic        sys_clk;
    logic        sys_rst;
    logic [7:0]  seg_in;
    logic [3:0]  sel_in;
    logic [15:0] digit_val;
    logic [3:0]  dp_val;
    logic [3:0]  digit_ok;
    logic        value_valid;
    logic        frame_done;
    logic        pattern_err;
    logic        sel_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] dv;
        logic [3:0]  dp;
        logic [3:0]  ok;
        logic        vv;
        logic        fd;
        logic        pe;
        logic        se;
        logic [7:0]  ec;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: plain arrays and a sample history
    logic [6:0]  legal_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0]  m_dig [4];
    logic        m_dp  [4];
    logic        m_ok  [4];
    logic [3:0]  m_seen;
    int          m_err;
    logic [11:0] hist[$];

    seg7_capture #(.STABLE_CYCLES(STABLE)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .seg_in      (seg_in),
        .sel_in      (sel_in),
        .digit_val   (digit_val),
        .dp_val      (dp_val),
        .digit_ok    (digit_ok),
        .value_valid (value_valid),
        .frame_done  (frame_done),
        .pattern_err (pattern_err),
        .sel_err     (sel_err),
        .err_cnt     (err_cnt)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic modelClear();
        for (int i = 0; i < 4; i++) begin
            m_dig[i] = 4'h0;
            m_dp[i]  = 1'b0;
            m_ok[i]  = 1'b0;
        end
        m_seen = 4'h0;
        m_err  = 0;
        hist.delete();
    endtask

    // Apply one accepted pair to the model and report the pulses it causes
    task automatic modelAccept(input logic [11:0] pair, output logic fd, output logic pe, output logic se);
        logic [7:0] seg;
        logic [3:0] sel;
        logic [3:0] tgt;
        int         idx;
        int         lows;
        logic       all_ok;
        seg  = pair[11:4];
        sel  = pair[3:0];
        fd   = 1'b0;
        pe   = 1'b0;
        se   = 1'b0;
        tgt  = 4'h0;
        lows = 4 - $countones(sel);
        if (sel == 4'hF) return;
        if (sel == 4'h0) tgt = 4'hF;
        else if (lows == 1) tgt = ~sel;
        else begin
            se = 1'b1;
            if (m_err < 255) m_err++;
            return;
        end
        idx = -1;
        for (int k = 0; k < 16; k++) if (legal_pat[k] == seg[6:0]) idx = k;
        if (idx >= 0) begin
            for (int i = 0; i < 4; i++) begin
                if (tgt[i]) begin
                    m_dig[i] = 4'(idx);
                    m_dp[i]  = ~seg[7];
                    m_ok[i]  = 1'b1;
                end
            end
            m_seen = m_seen | tgt;
            all_ok = m_ok[0] & m_ok[1] & m_ok[2] & m_ok[3];
            if (m_seen == 4'hF && all_ok) begin
                fd     = 1'b1;
                m_seen = 4'h0;
            end
        end else begin
            pe = 1'b1;
            for (int i = 0; i < 4; i++) if (tgt[i]) m_ok[i] = 1'b0;
            if (m_err < 255) m_err++;
        end
    endtask

    // One clock edge of the model: a pair is taken when the last STABLE samples match
    // and the sample before them (if any since reset) was different
    task automatic modelStep(input logic [7:0] seg, input logic [3:0] sel, input logic rst);
        exp_t e;
        logic fd, pe, se;
        logic run_ok;
        int   n;
        fd = 1'b0;
        pe = 1'b0;
        se = 1'b0;
        if (rst) begin
            modelClear();
        end else begin
            n = hist.size();
            if (n >= STABLE) begin
                run_ok = 1'b1;
                for (int k = 1; k < STABLE; k++) if (hist[n-1-k] != hist[n-1]) run_ok = 1'b0;
                if (n > STABLE && hist[n-1-STABLE] == hist[n-1]) run_ok = 1'b0;
                if (run_ok) modelAccept(hist[n-1], fd, pe, se);
            end
            hist.push_back({seg, sel});
            if (hist.size() > STABLE + 1) void'(hist.pop_front());
        end
        e.dv = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        e.dp = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
        e.ok = {m_ok[3], m_ok[2], m_ok[1], m_ok[0]};
        e.vv = m_ok[0] & m_ok[1] & m_ok[2] & m_ok[3];
        e.fd = fd;
        e.pe = pe;
        e.se = se;
        e.ec = 8'(m_err);
        exp_q.push_back(e);
    endtask

    // Drive a pair for a number of edges; each drive predicts the state after the next edge
    task automatic applyStimulus(input logic [7:0] seg, input logic [3:0] sel, input logic rst, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge sys_clk);
            seg_in  = seg;
            sel_in  = sel;
            sys_rst = rst;
            modelStep(seg, sel, rst);
        end
    endtask

    // Scoreboard monitor: compare every output once per edge against the queued prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("digit_val",   32'(digit_val),   32'(e.dv));
                checkOutput("dp_val",      32'(dp_val),      32'(e.dp));
                checkOutput("digit_ok",    32'(digit_ok),    32'(e.ok));
                checkOutput("value_valid", 32'(value_valid), 32'(e.vv));
                checkOutput("frame_done",  32'(frame_done),  32'(e.fd));
                checkOutput("pattern_err", 32'(pattern_err), 32'(e.pe));
                checkOutput("sel_err",     32'(sel_err),     32'(e.se));
                checkOutput("err_cnt",     32'(err_cnt),     32'(e.ec));
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rseg;
        logic [3:0] rsel;
        logic [3:0] sel_pool [6];
        sel_pool = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000, 4'b1111};
        sys_rst = 1'b1;
        seg_in  = 8'hFF;
        sel_in  = 4'hF;
        modelClear();
        applyStimulus(8'hFF, 4'hF, 1'b1, 3);

        // Broadcast of digit 2 to all positions
        applyStimulus(8'hA4, 4'b0000, 1'b0, 5);
        @(posedge sys_clk); #2;
        checkOutput("bcast_digits", 32'(digit_val), 32'h2222);
        checkOutput("bcast_ok",     32'(digit_ok),  32'hF);
        checkOutput("bcast_valid",  32'(value_valid), 32'd1);
        checkOutput("bcast_frame",  32'(frame_done),  32'd1);
        checkOutput("bcast_noerr",  32'(err_cnt),     32'd0);

        // Scanned digits 1..4
        applyStimulus(8'hF9, 4'b1110, 1'b0, 8);
        applyStimulus(8'hA4, 4'b1101, 1'b0, 8);
        applyStimulus(8'hB0, 4'b1011, 1'b0, 8);
        applyStimulus(8'h99, 4'b0111, 1'b0, 5);
        @(posedge sys_clk); #2;
        checkOutput("scan_digits", 32'(digit_val), 32'h4321);
        checkOutput("scan_frame",  32'(frame_done), 32'd1);
        applyStimulus(8'h99, 4'b0111, 1'b0, 3);

        // Short glitch must not be taken; the following pair needs its own full hold
        applyStimulus(8'hF9, 4'b1110, 1'b0, 3);
        applyStimulus(8'hC0, 4'b1110, 1'b0, 3);
        @(posedge sys_clk); #2;
        checkOutput("glitch_hold", 32'(digit_val), 32'h4321);
        applyStimulus(8'hC0, 4'b1110, 1'b0, 2);
        @(posedge sys_clk); #2;
        checkOutput("glitch_take", 32'(digit_val), 32'h4320);

        // Illegal segment pattern on digit 1
        applyStimulus(8'hFF, 4'b1101, 1'b0, 5);
        @(posedge sys_clk); #2;
        checkOutput("perr_pulse", 32'(pattern_err), 32'd1);
        checkOutput("perr_ok",    32'(digit_ok),    32'b1101);
        checkOutput("perr_valid", 32'(value_valid), 32'd0);
        checkOutput("perr_keep",  32'(digit_val),   32'h4320);
        checkOutput("perr_cnt",   32'(err_cnt),     32'd1);

        // Illegal select, then enough of them to saturate the counter
        applyStimulus(8'hA4, 4'b1100, 1'b0, 5);
        @(posedge sys_clk); #2;
        checkOutput("serr_pulse", 32'(sel_err),   32'd1);
        checkOutput("serr_keep",  32'(digit_val), 32'h4320);
        checkOutput("serr_cnt",   32'(err_cnt),   32'd2);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(8'hA4, (k % 2 == 0) ? 4'b1010 : 4'b1100, 1'b0, 4);
        end
        applyStimulus(8'hFF, 4'hF, 1'b0, 2);
        @(posedge sys_clk); #2;
        checkOutput("err_saturate", 32'(err_cnt), 32'd255);

        // Reset in the middle of a hold discards the partial run
        applyStimulus(8'hA4, 4'b1110, 1'b0, 2);
        applyStimulus(8'hA4, 4'b1110, 1'b1, 2);
        @(posedge sys_clk); #2;
        checkOutput("rst_digits", 32'(digit_val), 32'h0);
        checkOutput("rst_ok",     32'(digit_ok),  32'h0);
        checkOutput("rst_cnt",    32'(err_cnt),   32'h0);
        applyStimulus(8'hA4, 4'b1110, 1'b0, 4);
        @(posedge sys_clk); #2;
        checkOutput("rst_not_yet", 32'(digit_val), 32'h0);
        applyStimulus(8'hA4, 4'b1110, 1'b0, 1);
        @(posedge sys_clk); #2;
        checkOutput("rst_capture", 32'(digit_val), 32'h0002);
        checkOutput("rst_cap_ok",  32'(digit_ok),  32'b0001);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                applyStimulus(8'hFF, 4'hF, 1'b1, $urandom_range(1, 2));
            end else begin
                if ($urandom_range(0, 9) < 8) rseg = {1'($urandom_range(0, 1)), legal_pat[$urandom_range(0, 15)]};
                else rseg = 8'($urandom);
                if ($urandom_range(0, 7) < 6) rsel = sel_pool[$urandom_range(0, 5)];
                else rsel = 4'($urandom);
                applyStimulus(rseg, rsel, 1'b0, $urandom_range(1, 7));
            end
        end
        applyStimulus(8'hFF, 4'hF, 1'b0, 2);
        @(posedge sys_clk); #3;
        checkOutput("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
